// File: rtl/hpdcache_mshr_sched.sv
// Command scheduler for the single-port HPDcache MSHR: arbitrates check/alloc against ack
// with a bounded ack burst, and drains the MSHR on flush. Optional stall counters: HPDCACHE_MSHR_SCHED_STATS_EN.
module hpdcache_mshr_sched #(
   parameter int unsigned AckMaxBurst = 4,
   parameter int unsigned StatsWidth  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  chk_valid_i,
   output logic                  chk_ready_o,
   output logic                  chk_rsp_valid_o,
   output logic                  chk_rsp_hit_o,
   output logic                  chk_rsp_full_o,
   input  logic                  alloc_req_i,
   input  logic                  ack_valid_i,
   output logic                  ack_ready_o,
   output logic                  ack_rsp_valid_o,
   input  logic                  flush_i,
   output logic                  flush_done_o,
   output logic                  mshr_check_o,
   output logic                  mshr_alloc_o,
   output logic                  mshr_alloc_cs_o,
   output logic                  mshr_ack_o,
   output logic                  mshr_ack_cs_o,
   input  logic                  mshr_hit_i,
   input  logic                  mshr_alloc_full_i,
   input  logic                  mshr_empty_i,
   output logic [StatsWidth-1:0] stat_chk_stall_o,
   output logic [StatsWidth-1:0] stat_ack_stall_o
);
   localparam int unsigned BurstW = $clog2(AckMaxBurst + 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CHK_RSP    = 2'd1,
      FLUSH_WAIT = 2'd2
   } state_e;

   state_e              state_r;
   logic [BurstW-1:0]   burst_cnt_r;
   logic                flush_pend_r;
   logic                ack_rsp_r;

   logic                in_rsp_s;
   logic                grant_en_s;
   logic                starve_s;
   logic                ack_gnt_s;
   logic                chk_gnt_s;
   logic                done_s;
   logic                alloc_s;

   // Grant arbitration; grants are gated by rst_ni so every output reads 0 while in reset.
   always_comb begin
      in_rsp_s   = (state_r == CHK_RSP);
      grant_en_s = rst_ni & ~in_rsp_s;
      starve_s   = chk_valid_i & ~flush_pend_r & (burst_cnt_r == BurstW'(AckMaxBurst));
      ack_gnt_s  = grant_en_s & ack_valid_i & ~starve_s;
      chk_gnt_s  = grant_en_s & chk_valid_i & ~flush_pend_r & ~ack_gnt_s;
      done_s     = (state_r == FLUSH_WAIT) & mshr_empty_i & ~ack_gnt_s;
      alloc_s    = in_rsp_s & alloc_req_i & ~mshr_hit_i & ~mshr_alloc_full_i;
   end

   assign chk_ready_o     = chk_gnt_s;
   assign mshr_check_o    = chk_gnt_s;
   assign ack_ready_o     = ack_gnt_s;
   assign mshr_ack_o      = ack_gnt_s;
   assign mshr_ack_cs_o   = ack_gnt_s;
   assign chk_rsp_valid_o = in_rsp_s;
   assign chk_rsp_hit_o   = in_rsp_s & mshr_hit_i;
   assign chk_rsp_full_o  = in_rsp_s & mshr_alloc_full_i;
   assign mshr_alloc_o    = alloc_s;
   assign mshr_alloc_cs_o = alloc_s;
   assign flush_done_o    = done_s;
   assign ack_rsp_valid_o = ack_rsp_r;

   // Scheduler FSM with burst counter and flush-pending flag; done clears the flag even if flush_i is still high.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r      <= IDLE;
         burst_cnt_r  <= '0;
         flush_pend_r <= 1'b0;
         ack_rsp_r    <= 1'b0;
      end else begin
         ack_rsp_r <= ack_gnt_s;
         if (done_s) begin
            flush_pend_r <= 1'b0;
         end else if (flush_i) begin
            flush_pend_r <= 1'b1;
         end else begin
            flush_pend_r <= flush_pend_r;
         end
         if (chk_gnt_s || !chk_valid_i) begin
            burst_cnt_r <= '0;
         end else if (ack_gnt_s && (burst_cnt_r != BurstW'(AckMaxBurst))) begin
            burst_cnt_r <= burst_cnt_r + BurstW'(1);
         end else begin
            burst_cnt_r <= burst_cnt_r;
         end
         case (state_r)
            IDLE: begin
               if (chk_gnt_s) begin
                  state_r <= CHK_RSP;
               end else if (flush_pend_r) begin
                  state_r <= FLUSH_WAIT;
               end else begin
                  state_r <= IDLE;
               end
            end
            CHK_RSP: begin
               state_r <= flush_pend_r ? FLUSH_WAIT : IDLE;
            end
            FLUSH_WAIT: begin
               state_r <= done_s ? IDLE : FLUSH_WAIT;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

`ifdef HPDCACHE_MSHR_SCHED_STATS_EN
   logic [StatsWidth-1:0] chk_stall_r;
   logic [StatsWidth-1:0] ack_stall_r;

   // Saturating stall counters.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         chk_stall_r <= '0;
         ack_stall_r <= '0;
      end else begin
         if (chk_valid_i && !chk_gnt_s && (chk_stall_r != '1)) begin
            chk_stall_r <= chk_stall_r + StatsWidth'(1);
         end else begin
            chk_stall_r <= chk_stall_r;
         end
         if (ack_valid_i && !ack_gnt_s && (ack_stall_r != '1)) begin
            ack_stall_r <= ack_stall_r + StatsWidth'(1);
         end else begin
            ack_stall_r <= ack_stall_r;
         end
      end
   end

   assign stat_chk_stall_o = chk_stall_r;
   assign stat_ack_stall_o = ack_stall_r;
`else
   assign stat_chk_stall_o = '0;
   assign stat_ack_stall_o = '0;
`endif

endmodule

// File: tb/tb_hpdcache_mshr_sched.sv
// Scoreboard bench for hpdcache_mshr_sched: directed scenarios then random traffic,
// checked against a cycle-level reference model of the scheduling rules.
module tb_hpdcache_mshr_sched;
   localparam int MAXB = 4;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic chk_valid = 1'b0, alloc_req = 1'b0, ack_valid = 1'b0, flush = 1'b0;
   logic mshr_hit = 1'b0, mshr_full = 1'b0, mshr_empty = 1'b0;
   logic chk_ready, chk_rsp_valid, chk_rsp_hit, chk_rsp_full, ack_ready, ack_rsp_valid, flush_done;
   logic mshr_check, mshr_alloc, mshr_alloc_cs, mshr_ack, mshr_ack_cs;
   logic [31:0] stat_chk, stat_ack;

   always #5 clk = ~clk;

   hpdcache_mshr_sched #(.AckMaxBurst(MAXB), .StatsWidth(32)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .chk_valid_i(chk_valid), .chk_ready_o(chk_ready),
      .chk_rsp_valid_o(chk_rsp_valid), .chk_rsp_hit_o(chk_rsp_hit), .chk_rsp_full_o(chk_rsp_full),
      .alloc_req_i(alloc_req), .ack_valid_i(ack_valid), .ack_ready_o(ack_ready),
      .ack_rsp_valid_o(ack_rsp_valid), .flush_i(flush), .flush_done_o(flush_done),
      .mshr_check_o(mshr_check), .mshr_alloc_o(mshr_alloc), .mshr_alloc_cs_o(mshr_alloc_cs),
      .mshr_ack_o(mshr_ack), .mshr_ack_cs_o(mshr_ack_cs),
      .mshr_hit_i(mshr_hit), .mshr_alloc_full_i(mshr_full), .mshr_empty_i(mshr_empty),
      .stat_chk_stall_o(stat_chk), .stat_ack_stall_o(stat_ack)
   );

   typedef struct packed {
      logic        chk_g, rsp, hit, full, alloc, ack_g, ack_rsp, done;
      logic [31:0] cs, as;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model state: expressed in terms of "a check answer is due", "an ack answer is due",
   // "flush pending", "draining" and "acks granted in a row while a check waited".
   bit       m_rsp_due = 0, m_ack_due = 0, m_fp = 0, m_drain = 0, m_done = 0;
   int       m_row = 0;
   int       m_cs = 0, m_as = 0;

   task automatic step(input bit rst, input bit cv, input bit ar, input bit av, input bit fl,
                       input bit h, input bit f, input bit e);
      exp_t x;
      bit   starving, ag, cg;
      @(negedge clk);
      rst_ni = rst; chk_valid = cv; alloc_req = ar; ack_valid = av; flush = fl;
      mshr_hit = h; mshr_full = f; mshr_empty = e;
      #1;
      x = '0;
      if (!rst) begin
         m_rsp_due = 0; m_ack_due = 0; m_fp = 0; m_drain = 0; m_row = 0; m_cs = 0; m_as = 0; m_done = 0;
      end else begin
         starving = cv && !m_fp && (m_row == MAXB);
         ag = !m_rsp_due && av && !starving;
         cg = !m_rsp_due && cv && !m_fp && !ag;
         x.chk_g = cg; x.ack_g = ag;
         x.rsp = m_rsp_due; x.hit = m_rsp_due && h; x.full = m_rsp_due && f;
         x.alloc = m_rsp_due && ar && !h && !f;
         x.ack_rsp = m_ack_due;
         m_done = m_drain && e && !ag;
         x.done = m_done;
         x.cs = m_cs; x.as = m_as;
`ifdef HPDCACHE_MSHR_SCHED_STATS_EN
         x.cs = m_cs; x.as = m_as;
         if (cv && !cg) m_cs++;
         if (av && !ag) m_as++;
`else
         x.cs = 0; x.as = 0;
`endif
         m_drain   = m_fp && !m_done;
         m_fp      = m_done ? 1'b0 : (m_fp || fl);
         m_rsp_due = cg;
         m_ack_due = ag;
         if (!cv || cg) m_row = 0;
         else if (ag && m_row < MAXB) m_row++;
      end
      exp_q.push_back(x);
   endtask

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
      end
   endtask

   // Monitor: pops one expected record per driven cycle and compares every output.
   always @(negedge clk) begin
      exp_t x;
      #3;
      if (exp_q.size() > 0) begin
         x = exp_q.pop_front();
         cmp("chk_ready", chk_ready, x.chk_g);
         cmp("mshr_check", mshr_check, x.chk_g);
         cmp("chk_rsp_valid", chk_rsp_valid, x.rsp);
         cmp("chk_rsp_hit", chk_rsp_hit, x.hit);
         cmp("chk_rsp_full", chk_rsp_full, x.full);
         cmp("mshr_alloc", mshr_alloc, x.alloc);
         cmp("mshr_alloc_cs", mshr_alloc_cs, x.alloc);
         cmp("ack_ready", ack_ready, x.ack_g);
         cmp("mshr_ack", mshr_ack, x.ack_g);
         cmp("mshr_ack_cs", mshr_ack_cs, x.ack_g);
         cmp("ack_rsp_valid", ack_rsp_valid, x.ack_rsp);
         cmp("flush_done", flush_done, x.done);
         cmp("stat_chk_stall", stat_chk, x.cs);
         cmp("stat_ack_stall", stat_ack, x.as);
         cmp("ack_vs_check_exclusive", mshr_ack & (mshr_check | mshr_alloc), 1'b0);
      end
   end

   initial begin
      int guard;
      bit fl;
      // reset state
      repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
      // single check, hit with alloc request
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 1, 0, 0);
      // miss with alloc, then set-full
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0, 1, 0);
      step(1, 0, 1, 0, 0, 0, 0, 0);
      // starvation bound and simultaneous request with empty burst counter
      repeat (14) step(1, 1, 0, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      // flush with two acks outstanding while a check waits
      step(1, 1, 0, 1, 1, 0, 0, 0);
      step(1, 1, 0, 1, 1, 0, 0, 0);
      repeat (2) step(1, 1, 0, 0, 1, 0, 0, 0);
      guard = 0;
      while (!m_done && guard < 10) begin
         step(1, 1, 0, 0, 1, 0, 0, 1);
         guard++;
      end
      cmp("flush_done_seen", m_done, 1'b1);
      step(1, 1, 0, 0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0, 0, 0, 1);
      // reset while in the check-response cycle
      step(1, 1, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0, 1, 1, 1);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         fl = ($urandom_range(0, 29) == 0) || (m_fp && ($urandom_range(0, 7) != 0));
         step(($urandom_range(0, 599) != 0),
              ($urandom_range(0, 2) != 0), $urandom_range(0, 1), ($urandom_range(0, 2) == 0),
              fl, $urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      end
      step(1, 0, 0, 0, 0, 0, 0, 1);
      guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      #5;
      cmp("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
